// File: rtl/ex_div_seq_pkg.sv
// Shared definitions for the EX-stage divide sequencer: FSM state
// encodings, result-ready flags, start/stop request levels and the
// stall-request levels driven towards the pipeline controller.
package ex_div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

endpackage

// File: rtl/ex_div_seq_div_step.sv
// One restoring division step: shift the partial remainder left by one,
// bring in the next dividend bit, and subtract the divisor if it fits.
// The quotient bit is 1 when the subtraction does not borrow.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic              bit_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              q_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // Trial subtraction one bit wider than the operands so the borrow is visible
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, divisor_i};
        q_o     = ~diff[DATA_W];
        rem_o   = q_o ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/ex_div_seq.sv
// Multi-cycle divide sequencer for the EX stage. Produces {remainder,
// quotient} for DIV/DIVU one quotient bit per cycle and stalls the
// pipeline until the result is ready. Operands are captured once on
// acceptance; magnitudes are divided and the signs are fixed up at the end.
// Optional feature macro: DIV_EARLY_OUT_EN -- when defined, a divide whose
// dividend magnitude is below the divisor magnitude finishes immediately.
module ex_div_seq
    import ex_div_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                stallreq_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    div_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] divisor_q;
    logic              neg_quo_q;
    logic              neg_rem_q;

    logic              dvd_neg;
    logic              dvs_neg;
    logic [DATA_W-1:0] dvd_mag;
    logic [DATA_W-1:0] dvs_mag;
    logic              early_out;

    logic [DATA_W-1:0] step_rem;
    logic              step_q;
    logic [DATA_W-1:0] quo_next;
    logic [DATA_W-1:0] final_quo;
    logic [DATA_W-1:0] final_rem;

    // Operand magnitudes and the early-out decision, taken from the live inputs in IDLE
    always_comb begin
        dvd_neg = signed_div_i & opdata1_i[DATA_W-1];
        dvs_neg = signed_div_i & opdata2_i[DATA_W-1];
        dvd_mag = dvd_neg ? -opdata1_i : opdata1_i;
        dvs_mag = dvs_neg ? -opdata2_i : opdata2_i;
`ifdef DIV_EARLY_OUT_EN
        early_out = (dvd_mag < dvs_mag);
`else
        early_out = 1'b0;
`endif
    end

    div_step #(
        .DATA_W(DATA_W)
    ) u_div_step (
        .rem_i    (rem_q),
        .bit_i    (quo_q[DATA_W-1]),
        .divisor_i(divisor_q),
        .rem_o    (step_rem),
        .q_o      (step_q)
    );

    // Result of the current step with the sign fix-up applied for the final write
    always_comb begin
        quo_next  = {quo_q[DATA_W-2:0], step_q};
        final_quo = neg_quo_q ? -quo_next : quo_next;
        final_rem = neg_rem_q ? -step_rem : step_rem;
    end

    // Stall while a divide is being accepted or is running; never during reset or annul
    always_comb begin
        stallreq_o = NO_STOP;
        if (!rst && !annul_i) begin
            case (state)
                DIV_FREE:            stallreq_o = (start_i == DIV_START) ? STOP : NO_STOP;
                DIV_BY_ZERO, DIV_ON: stallreq_o = STOP;
                default:             stallreq_o = NO_STOP;
            endcase
        end
    end

    // Divide FSM with step counter, datapath registers and registered result/ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DIV_FREE;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_o  <= '0;
            ready_o   <= DIV_RESULT_NOT_READY;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (start_i == DIV_START && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= DIV_BY_ZERO;
                        end else if (early_out) begin
                            state    <= DIV_END;
                            result_o <= {opdata1_i, {DATA_W{1'b0}}};
                            ready_o  <= DIV_RESULT_READY;
                        end else begin
                            state     <= DIV_ON;
                            cnt       <= '0;
                            rem_q     <= '0;
                            quo_q     <= dvd_mag;
                            divisor_q <= dvs_mag;
                            neg_quo_q <= dvd_neg ^ dvs_neg;
                            neg_rem_q <= dvd_neg;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    state    <= DIV_END;
                    result_o <= '0;
                    ready_o  <= DIV_RESULT_READY;
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state <= DIV_FREE;
                    end else begin
                        rem_q <= step_rem;
                        quo_q <= quo_next;
                        cnt   <= cnt + CNT_W'(1);
                        if (cnt == LAST_STEP) begin
                            state    <= DIV_END;
                            result_o <= {final_rem, final_quo};
                            ready_o  <= DIV_RESULT_READY;
                        end
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP || annul_i) begin
                        state    <= DIV_FREE;
                        result_o <= '0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: doc/ex_div_seq.md
# ex_div_seq

Multi-cycle divide sequencer for the EX stage. The EX stage decodes a DIV/DIVU op and hands two 32-bit operands to this block. The block then runs an iterative shift-subtract division, one quotient bit per cycle, and holds the pipeline stalled until a {remainder, quotient} result is ready for HI/LO write-back. It owns the divide FSM, the step counter, the start/annul/ready handshake and the stall request to the pipeline controller.

## Interface
Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  request; held high by EX until ready_o is seen.
- annul_i  in  1  abort the current divide (branch-delay flush or exception).
- result_o  out  2*DATA_W  {remainder, quotient}; registered.
- ready_o  out  1  result valid; registered.
- stallreq_o  out  1  stall request to the pipeline controller; combinational.

## Operation
- FSM states:
  - IDLE: on start_i=1 and annul_i=0, samples signed_div_i, opdata1_i and opdata2_i.
    - Divisor == 0: go to DIVZERO.
    - Otherwise: go to ON. Load the magnitudes: in signed mode, negative operands are two's-complemented. Clear the counter.
    - start_i with annul_i at the same time: stay in IDLE.
  - DIVZERO: unconditionally go to END with result_o = 0.
  - ON: each cycle performs one restoring step (shift partial remainder left 1, subtract divisor; quotient bit = no-borrow).
    - The counter runs 0..DATA_W-1.
    - After step DATA_W-1, go to END and load result_o with sign correction:
      - quotient negated if signed and operand signs differ;
      - remainder negated if signed and dividend negative.
    - annul_i=1: go to IDLE immediately; result_o and ready_o are unchanged (0).
  - END: ready_o=1 and result_o stable.
    - Stay while start_i=1 and annul_i=0.
    - Return to IDLE (ready_o←0, result_o←0) when start_i=0 or annul_i=1.
- Operands are captured once in IDLE; later input changes are ignored.
- Arithmetic is modulo 2^DATA_W: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- Remainder sign follows the dividend; |remainder| < |divisor|.
- stallreq_o = 1 when:
  - (state==IDLE & start_i & ~annul_i), or
  - state ∈ {DIVZERO, ON}.
  - It is 0 in END and whenever annul_i=1.
- rst takes effect on the next edge from any state, including mid-divide:
  - state←IDLE, counter←0, result_o←0, ready_o←0.
  - stallreq_o = 0 while rst=1.

## Timing
- Edge E0 samples start_i in IDLE.
- Normal divide: steps on E1..E(DATA_W); ready_o high after E(DATA_W).
  - DATA_W+1 cycles from request to ready; 33 at default.
- Divide by zero: ready_o after E1; 2 cycles.
- ready_o and result_o are high for at least one cycle. They drop one edge after start_i falls.
- Back-to-back requests: a new start_i is accepted only in IDLE. There is a minimum of 1 idle cycle between results.

## Configuration
- DIV_EARLY_OUT_EN:
  - Defined: in IDLE, if divisor ≠ 0 and |dividend| < |divisor|, go directly to END. Result is quotient 0, remainder = original dividend (sign preserved); ready_o after E0, so 1 cycle.
  - Undefined: these cases take the full DATA_W+1 cycles and give an identical result.

## Structure
- Shared defines file (defines.v):
  - state encodings DivFree/DivByZero/DivOn/DivEnd;
  - DivResultReady/DivResultNotReady;
  - DivStart/DivStop;
  - stall-request constants.
- Sub-module div_step: combinational single shift-subtract step (partial remainder in, divisor in → next partial remainder, quotient bit). It is instantiated once in ex_div_seq.

## Test plan
- Unsigned 100/7: ready_o at cycle 33; result_o = 0x00000002_0000000E; stallreq_o high for cycles 0–32, low at 33.
- Signed −100/7: result_o = 0xFFFFFFFE_FFFFFFF2 (rem −2, quo −14). Signed 100/−7: 0x00000002_FFFFFFF2.
- Signed 0x80000000 / 0xFFFFFFFF: result_o = 0x00000000_80000000. Unsigned 0xFFFFFFFF/1: 0x00000000_FFFFFFFF.
- Divide by zero 5/0: ready_o at cycle 2; result_o = 0; stallreq_o high cycles 0–1.
- Annul at step 10: ready_o never rises and state returns to IDLE. A following unsigned 9/3 gives 0x00000000_00000003 at cycle 33. Apply rst at step 5: the same recovery is required.
- 3/10 unsigned: with DIV_EARLY_OUT_EN, ready_o at cycle 1; without it, at cycle 33. Both give 0x00000003_00000000.
